// File: rtl/seq_pkg.sv
// Shared types, defaults and the pattern border function for the overlapping sequence blocks.
package seq_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned MAX_W     = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_FULL = 2'd1,
        SEND_TAIL = 2'd2,
        DONE      = 2'd3
    } seq_state_e;

    // Longest proper prefix of the w-bit pattern (MSB first) that is also its suffix.
    function automatic int unsigned border_len(input logic [MAX_W-1:0] pat, input int unsigned w);
        int unsigned     best;
        logic [MAX_W-1:0] mask;
        best = 0;
        for (int unsigned b = 1; b < MAX_W; b++) begin
            mask = (MAX_W'(1) << b) - MAX_W'(1);
            if ((b < w) && (((pat >> (w - b)) & mask) == (pat & mask))) begin
                best = b;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_border_calc.sv
// Combinational pattern-to-border-length calculator; result is registered by the caller.
module seq_border_calc
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDX_W = $clog2(DEF_WIDTH)
) (
    input  logic [WIDTH-1:0] pattern,
    output logic [IDX_W-1:0] border_c
);

    // Border is at most WIDTH-1, so it always fits the index width.
    assign border_c = IDX_W'(border_len(MAX_W'(pattern), WIDTH));

endmodule

// File: rtl/overlapping_sequence_generator.sv
// Serial transmitter emitting N overlapping occurrences of a pattern over valid/ready.
module overlapping_sequence_generator
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] count,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] tail_q, tail_d;       // K-1: first index of each tail repetition
    logic [IDX_W-1:0] border_c;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    seq_border_calc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_border (
        .pattern  (pattern),
        .border_c (border_c)
    );

    // Next-state, counters and look-ahead of the registered outputs.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        tail_d  = tail_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    rem_d   = count;
                    tail_d  = IDX_W'(WIDTH - 1) - border_c;
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = (count == '0) ? DONE : SEND_FULL;
                end
            end
            SEND_FULL, SEND_TAIL: begin
                if (bit_ready) begin
                    if (idx_q == '0) begin
                        rem_d = rem_q - CNT_W'(1);
                        idx_d = tail_q;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = SEND_TAIL;
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bit_valid_d = (state_d == SEND_FULL) || (state_d == SEND_TAIL);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        bit_out_d   = bit_valid_d ? pat_d[idx_d] : 1'b0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            tail_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            tail_q      <= tail_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_overlapping_sequence_generator.sv
// Bench for overlapping_sequence_generator against a string-based reference model.
module tb_overlapping_sequence_generator;
    import seq_pkg::*;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [CW-1:0] count = '0;
    logic          bit_ready = 1'b0;
    logic          bit_out, bit_valid, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    overlapping_sequence_generator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pattern   (pattern),
        .count     (count),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done)
    );

    function automatic string pat_str(input logic [W-1:0] p);
        return $sformatf("%b", p);
    endfunction

    // Longest proper prefix equal to suffix, by direct substring comparison.
    function automatic int ref_border(input logic [W-1:0] p);
        string s;
        int best;
        s = pat_str(p);
        best = 0;
        for (int b = 1; b < W; b++) begin
            if (s.substr(0, b - 1) == s.substr(W - b, W - 1)) best = b;
        end
        return best;
    endfunction

    function automatic string ref_stream(input logic [W-1:0] p, input int n);
        string s, tail, r;
        s = pat_str(p);
        if (n == 0) return "";
        tail = s.substr(ref_border(p), W - 1);
        r = s;
        for (int i = 1; i < n; i++) r = {r, tail};
        return r;
    endfunction

    // Overlapping-occurrence detector over a received bit string.
    function automatic int detect(input string stream, input string s);
        int c;
        c = 0;
        for (int i = 0; i + W <= stream.len(); i++) begin
            if (stream.substr(i, i + W - 1) == s) c++;
        end
        return c;
    endfunction

    // Launch one burst from the current negedge and collect it until the done pulse.
    task automatic run_burst(input logic [W-1:0] pat, input int cnt, input bit rnd,
                             input bit hold_start, input string name, output string got);
        string exp_s;
        int    c, done_cyc, det;
        bit    prev_stall, br;
        logic  prev_bit;
        exp_s = ref_stream(pat, cnt);
        got = "";
        start = 1'b1; pattern = pat; count = CW'(cnt); bit_ready = 1'b1;
        @(negedge clk);
        c = 1; done_cyc = -1; prev_stall = 1'b0; prev_bit = 1'b0;
        while (done_cyc < 0 && c < 5000) begin
            start = hold_start;
            pattern = W'($urandom);
            count = CW'($urandom);
            br = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bit_ready = br;
            if (prev_stall) begin
                checks++;
                if (bit_valid !== 1'b1 || bit_out !== prev_bit) begin
                    failures++;
                    $display("FAIL %s stall_hold c=%0d: valid=%b bit=%b required valid=1 bit=%b",
                             name, c, bit_valid, bit_out, prev_bit);
                end
            end
            if (bit_valid === 1'b1 && br) begin
                if (!rnd) begin
                    checks++;
                    if (c != got.len() + 1) begin
                        failures++;
                        $display("FAIL %s bit_timing: bit %0d at cycle %0d required %0d",
                                 name, got.len(), c, got.len() + 1);
                    end
                end
                got = $sformatf("%s%0d", got, bit_out);
            end
            prev_stall = (bit_valid === 1'b1) && !br;
            prev_bit = bit_out;
            if (done === 1'b1) begin
                done_cyc = c;
                checks++;
                if (busy !== 1'b1 || bit_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_cycle: busy=%b valid=%b required busy=1 valid=0",
                             name, busy, bit_valid);
                end
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles", name, c);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bit_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: busy=%b done=%b valid=%b required all 0",
                     name, busy, done, bit_valid);
        end
        if (!rnd) begin
            checks++;
            if (done_cyc != exp_s.len() + 1) begin
                failures++;
                $display("FAIL %s done_timing: cycle %0d required %0d", name, done_cyc, exp_s.len() + 1);
            end
        end
        checks++;
        if (got != exp_s) begin
            failures++;
            $display("FAIL %s stream: got %s required %s", name, got, exp_s);
        end
        det = detect(got, pat_str(pat));
        checks++;
        if (det != cnt) begin
            failures++;
            $display("FAIL %s detector: %0d matches required %0d", name, det, cnt);
        end
    endtask

    task automatic test_reset();
        string got;
        @(negedge clk);
        checks++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: outs=%b required 0000", {bit_out, bit_valid, busy, done});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bit_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: outs=%b required 000", {bit_valid, busy, done});
        end
        got = "";
    endtask

    task automatic test_basic();
        string got;
        run_burst(4'b1011, 3, 1'b0, 1'b0, "basic_1011", got);
        checks++;
        if (got != "1011011011") begin
            failures++;
            $display("FAIL basic_literal: got %s required 1011011011", got);
        end
    endtask

    task automatic test_border_cases();
        logic [W-1:0] pats [4] = '{4'b1111, 4'b1010, 4'b1000, 4'b1011};
        int           cnts [4] = '{3, 2, 2, 1};
        string        lits [4] = '{"111111", "101010", "10001000", "1011"};
        int           bord [4] = '{3, 2, 0, 1};
        string got;
        int    b;
        for (int i = 0; i < 4; i++) begin
            b = int'(border_len(MAX_W'(pats[i]), W));
            checks++;
            if (b != bord[i] || ref_border(pats[i]) != bord[i]) begin
                failures++;
                $display("FAIL border_len %b: pkg=%0d model=%0d required %0d",
                         pats[i], b, ref_border(pats[i]), bord[i]);
            end
            run_burst(pats[i], cnts[i], 1'b0, 1'b0, "border_case", got);
            checks++;
            if (got != lits[i]) begin
                failures++;
                $display("FAIL border_literal %b: got %s required %s", pats[i], got, lits[i]);
            end
        end
    endtask

    task automatic test_stall();
        string ref_got, got;
        run_burst(4'b1101, 4, 1'b0, 1'b0, "stall_ref", ref_got);
        for (int i = 0; i < 3; i++) begin
            run_burst(4'b1101, 4, 1'b1, 1'b0, "stall_rnd", got);
            checks++;
            if (got != ref_got) begin
                failures++;
                $display("FAIL stall_vs_nostall: got %s required %s", got, ref_got);
            end
        end
    endtask

    task automatic test_zero_count();
        string got;
        run_burst(4'b0110, 0, 1'b0, 1'b0, "zero_count", got);
        run_burst(4'b1001, 0, 1'b1, 1'b1, "zero_count_hold", got);
    endtask

    task automatic test_start_ignored();
        string got;
        run_burst(4'b1100, 2, 1'b0, 1'b1, "start_busy", got);
        run_burst(4'b0101, 3, 1'b1, 1'b1, "start_busy_rnd", got);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || bit_valid !== 1'b0) begin
                failures++;
                $display("FAIL no_second_burst: busy=%b valid=%b required 0 0", busy, bit_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        string got;
        for (int i = 0; i < 6; i++) begin
            run_burst(W'($urandom), $urandom_range(1, 6), 1'b1, 1'b0, "random", got);
        end
        run_burst(4'b1001, 2, 1'b0, 1'b0, "b2b_a", got);
        run_burst(4'b0110, 3, 1'b0, 1'b0, "b2b_b", got);
    endtask

    task automatic test_max_count();
        string got;
        run_burst(4'b1011, 255, 1'b0, 1'b0, "max_count", got);
    endtask

    task automatic test_reset_mid_burst();
        string got;
        start = 1'b1; pattern = 4'b1101; count = CW'(10); bit_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async: outs=%b required 0000", {bit_out, bit_valid, busy, done});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_resume: valid=%b busy=%b required 0 0", bit_valid, busy);
        end
        run_burst(4'b1101, 10, 1'b0, 1'b0, "after_reset", got);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_border_cases();
        test_stall();
        test_zero_count();
        test_start_ignored();
        test_back_to_back();
        test_max_count();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
